// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-port (fetch/data) arbiter onto a single external memory bus
//
// Purpose:
//   Grants one transaction at a time to either the instruction fetch port or the
//   data port. The winner's fields are registered onto the bus, and the arbiter
//   then waits for busAck or a timeout. The result goes back to the requester
//   together with a one-cycle ready pulse. Data normally wins arbitration. After
//   STARVE_LIMIT back-to-back data grants made while a fetch was waiting, the
//   fetch is granted instead.
//
// Ports:
//   clk, resetn                       clock, asynchronous active-low reset
//   instReq/instAddr                  fetch request, held until instReady
//   instReady/instRdata/instErr       fetch response (ready is a 1-cycle pulse)
//   dataReq/dataWe/dataBe/dataAddr/dataWdata   load/store request, held until dataReady
//   dataReady/dataRdata/dataErr       data response (ready is a 1-cycle pulse)
//   busReq/busWe/busBe/busAddr/busWdata        registered bus request fields
//   busAck/busRdata                   bus completion, read data valid with ack
module mem_bus_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int TIMEOUT      = 255,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                instReq,
  input  logic [ADDR_W-1:0]   instAddr,
  output logic                instReady,
  output logic [DATA_W-1:0]   instRdata,
  output logic                instErr,
  input  logic                dataReq,
  input  logic                dataWe,
  input  logic [DATA_W/8-1:0] dataBe,
  input  logic [ADDR_W-1:0]   dataAddr,
  input  logic [DATA_W-1:0]   dataWdata,
  output logic                dataReady,
  output logic [DATA_W-1:0]   dataRdata,
  output logic                dataErr,
  output logic                busReq,
  output logic                busWe,
  output logic [DATA_W/8-1:0] busBe,
  output logic [ADDR_W-1:0]   busAddr,
  output logic [DATA_W-1:0]   busWdata,
  input  logic                busAck,
  input  logic [DATA_W-1:0]   busRdata
);

  localparam int BE_W     = DATA_W / 8;
  localparam int WAIT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int STARVE_W = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [WAIT_W-1:0]   WAIT_MAX   = WAIT_W'(TIMEOUT);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_grant_data, w_grant_data_nxt;
  logic [STARVE_W-1:0] r_starve_cnt, w_starve_cnt_nxt;
  logic [WAIT_W-1:0]   r_wait_cnt, w_wait_cnt_nxt;

  logic                r_bus_req, w_bus_req_nxt;
  logic                r_bus_we, w_bus_we_nxt;
  logic [BE_W-1:0]     r_bus_be, w_bus_be_nxt;
  logic [ADDR_W-1:0]   r_bus_addr, w_bus_addr_nxt;
  logic [DATA_W-1:0]   r_bus_wdata, w_bus_wdata_nxt;
  logic                r_inst_ready, w_inst_ready_nxt;
  logic [DATA_W-1:0]   r_inst_rdata, w_inst_rdata_nxt;
  logic                r_inst_err, w_inst_err_nxt;
  logic                r_data_ready, w_data_ready_nxt;
  logic [DATA_W-1:0]   r_data_rdata, w_data_rdata_nxt;
  logic                r_data_err, w_data_err_nxt;

  logic w_pick_inst;
  logic w_timeout;

  // The fetch only beats a pending data request once it has been starved.
  assign w_pick_inst = instReq && (!dataReq || (r_starve_cnt == STARVE_MAX));
  // A zero TIMEOUT disables the timeout path.
  assign w_timeout   = (TIMEOUT != 0) && (r_wait_cnt == WAIT_MAX);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_grant_data <= 1'b0;
      r_starve_cnt <= '0;
      r_wait_cnt   <= '0;
      r_bus_req    <= 1'b0;
      r_bus_we     <= 1'b0;
      r_bus_be     <= '0;
      r_bus_addr   <= '0;
      r_bus_wdata  <= '0;
      r_inst_ready <= 1'b0;
      r_inst_rdata <= '0;
      r_inst_err   <= 1'b0;
      r_data_ready <= 1'b0;
      r_data_rdata <= '0;
      r_data_err   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant_data <= w_grant_data_nxt;
      r_starve_cnt <= w_starve_cnt_nxt;
      r_wait_cnt   <= w_wait_cnt_nxt;
      r_bus_req    <= w_bus_req_nxt;
      r_bus_we     <= w_bus_we_nxt;
      r_bus_be     <= w_bus_be_nxt;
      r_bus_addr   <= w_bus_addr_nxt;
      r_bus_wdata  <= w_bus_wdata_nxt;
      r_inst_ready <= w_inst_ready_nxt;
      r_inst_rdata <= w_inst_rdata_nxt;
      r_inst_err   <= w_inst_err_nxt;
      r_data_ready <= w_data_ready_nxt;
      r_data_rdata <= w_data_rdata_nxt;
      r_data_err   <= w_data_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_grant_data_nxt = r_grant_data;
    w_starve_cnt_nxt = r_starve_cnt;
    w_wait_cnt_nxt   = r_wait_cnt;
    w_bus_req_nxt    = r_bus_req;
    w_bus_we_nxt     = r_bus_we;
    w_bus_be_nxt     = r_bus_be;
    w_bus_addr_nxt   = r_bus_addr;
    w_bus_wdata_nxt  = r_bus_wdata;
    w_inst_ready_nxt = 1'b0;
    w_inst_rdata_nxt = r_inst_rdata;
    w_inst_err_nxt   = r_inst_err;
    w_data_ready_nxt = 1'b0;
    w_data_rdata_nxt = r_data_rdata;
    w_data_err_nxt   = r_data_err;

    unique case (r_state)
      S_IDLE: begin
        if (instReq || dataReq) begin
          w_state_nxt    = S_BUSY;
          w_bus_req_nxt  = 1'b1;
          w_wait_cnt_nxt = WAIT_W'(1);
          if (w_pick_inst) begin
            w_grant_data_nxt = 1'b0;
            w_bus_we_nxt     = 1'b0;
            w_bus_be_nxt     = '1;
            w_bus_addr_nxt   = instAddr;
            w_bus_wdata_nxt  = '0;
            w_starve_cnt_nxt = '0;
          end else begin
            w_grant_data_nxt = 1'b1;
            w_bus_we_nxt     = dataWe;
            w_bus_be_nxt     = dataBe;
            w_bus_addr_nxt   = dataAddr;
            w_bus_wdata_nxt  = dataWdata;
            // Only data grants that bypass a waiting fetch count toward starvation.
            if (!instReq)
              w_starve_cnt_nxt = '0;
            else if (r_starve_cnt != STARVE_MAX)
              w_starve_cnt_nxt = r_starve_cnt + STARVE_W'(1);
          end
        end
      end
      S_BUSY: begin
        // An ack that coincides with the timeout cycle still completes normally.
        if (busAck || w_timeout) begin
          w_state_nxt   = S_RESP;
          w_bus_req_nxt = 1'b0;
          if (r_grant_data) begin
            w_data_ready_nxt = 1'b1;
            w_data_rdata_nxt = busAck ? busRdata : '0;
            w_data_err_nxt   = !busAck;
          end else begin
            w_inst_ready_nxt = 1'b1;
            w_inst_rdata_nxt = busAck ? busRdata : '0;
            w_inst_err_nxt   = !busAck;
          end
        end else if (TIMEOUT != 0) begin
          w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign busReq    = r_bus_req;
  assign busWe     = r_bus_we;
  assign busBe     = r_bus_be;
  assign busAddr   = r_bus_addr;
  assign busWdata  = r_bus_wdata;
  assign instReady = r_inst_ready;
  assign instRdata = r_inst_rdata;
  assign instErr   = r_inst_err;
  assign dataReady = r_data_ready;
  assign dataRdata = r_data_rdata;
  assign dataErr   = r_data_err;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        instReq;
  logic [31:0] instAddr;
  logic        instReady;
  logic [31:0] instRdata;
  logic        instErr;
  logic        dataReq;
  logic        dataWe;
  logic [3:0]  dataBe;
  logic [31:0] dataAddr;
  logic [31:0] dataWdata;
  logic        dataReady;
  logic [31:0] dataRdata;
  logic        dataErr;
  logic        busReq;
  logic        busWe;
  logic [3:0]  busBe;
  logic [31:0] busAddr;
  logic [31:0] busWdata;
  logic        busAck;
  logic [31:0] busRdata;

  int n_vec = 0;
  int n_err = 0;

  mem_bus_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(8), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .resetn(resetn),
    .instReq(instReq), .instAddr(instAddr),
    .instReady(instReady), .instRdata(instRdata), .instErr(instErr),
    .dataReq(dataReq), .dataWe(dataWe), .dataBe(dataBe),
    .dataAddr(dataAddr), .dataWdata(dataWdata),
    .dataReady(dataReady), .dataRdata(dataRdata), .dataErr(dataErr),
    .busReq(busReq), .busWe(busWe), .busBe(busBe),
    .busAddr(busAddr), .busWdata(busWdata),
    .busAck(busAck), .busRdata(busRdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the bus request, checks its address, acks it at once
  // and checks the response pulse on the expected port.
  task automatic serve(input string tag, input logic [31:0] exp_addr,
                       input logic exp_inst, input logic [31:0] rd);
    int k = 0;
    while (busReq !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    chk({tag, "_busreq"}, busReq, 1);
    chk({tag, "_addr"}, busAddr, exp_addr);
    busRdata = rd;
    busAck   = 1'b1;
    step();
    busAck   = 1'b0;
    chk({tag, "_inst_ready"}, instReady, exp_inst);
    chk({tag, "_data_ready"}, dataReady, !exp_inst);
    chk({tag, "_rdata"}, exp_inst ? instRdata : dataRdata, rd);
  endtask

  logic [31:0] seq_addr [6];
  logic        seq_inst [6];

  initial begin
    resetn = 1'b0; instReq = 1'b0; instAddr = '0; dataReq = 1'b0; dataWe = 1'b0;
    dataBe = '0; dataAddr = '0; dataWdata = '0; busAck = 1'b0; busRdata = '0;
    seq_addr = '{32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'h00C0, 32'h3010};
    seq_inst = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    step();
    step();
    chk("rst_busreq", busReq, 0);
    chk("rst_outs", {instReady, instErr, dataReady, dataErr, busWe, busBe}, 0);
    chk("rst_data", {instRdata, dataRdata}, 0);
    chk("rst_bus", {busAddr, busWdata}, 0);
    resetn = 1'b1;
    step();

    // 1. Fetch only, ack in cycle 3
    instReq = 1'b1; instAddr = 32'h0000_0040;
    step();
    chk("t1_c1_busreq", busReq, 1);
    chk("t1_c1_fields", {busAddr, busWe, busBe}, {32'h40, 1'b0, 4'hF});
    step();
    chk("t1_c2_busreq", busReq, 1);
    step();
    chk("t1_c3_busreq", busReq, 1);
    busAck = 1'b1; busRdata = 32'h2402_0005;
    step();
    busAck = 1'b0;
    chk("t1_c4_ready", {instReady, dataReady, busReq}, 3'b100);
    chk("t1_c4_rdata", instRdata, 32'h2402_0005);
    chk("t1_c4_err", instErr, 0);
    instReq = 1'b0;
    step();
    chk("t1_c5_ready", instReady, 0);

    // 2. Simultaneous requests: data goes first
    instReq = 1'b1; instAddr = 32'h80;
    dataReq = 1'b1; dataWe = 1'b0; dataBe = 4'hF; dataAddr = 32'h1000;
    serve("t2_data", 32'h1000, 1'b0, 32'h1111_2222);
    dataReq = 1'b0;
    step();
    chk("t2_idle_busreq", busReq, 0);
    chk("t2_idle_ready", {instReady, dataReady}, 0);
    serve("t2_inst", 32'h80, 1'b1, 32'h3333_4444);
    instReq = 1'b0;
    step();

    // 3. Starvation: four data grants, one fetch, then data again
    instReq = 1'b1; instAddr = 32'hC0;
    dataReq = 1'b1; dataAddr = 32'h3000;
    for (int i = 0; i < 6; i++) begin
      serve("t3_grant", seq_addr[i], seq_inst[i], 32'hA000_0000 + i);
      if (seq_inst[i]) instReq = 1'b0;
      else dataAddr = dataAddr + 32'h4;
    end
    dataReq = 1'b0;
    step();

    // 4. Store fields held until ack
    dataReq = 1'b1; dataWe = 1'b1; dataBe = 4'b0011; dataAddr = 32'h2000;
    dataWdata = 32'hDEAD_BEEF;
    step();
    chk("t4_c1_fields", {busReq, busWe, busBe, busAddr, busWdata},
        {1'b1, 1'b1, 4'b0011, 32'h2000, 32'hDEAD_BEEF});
    step();
    chk("t4_c2_fields", {busReq, busWe, busBe, busAddr, busWdata},
        {1'b1, 1'b1, 4'b0011, 32'h2000, 32'hDEAD_BEEF});
    busAck = 1'b1; busRdata = 32'h0000_1234;
    step();
    busAck = 1'b0;
    chk("t4_c3_ready", {dataReady, busReq, dataErr}, 3'b100);
    dataReq = 1'b0; dataWe = 1'b0; dataBe = 4'hF;
    step();

    // 5a. Timeout after exactly 8 bus cycles, late ack ignored
    dataReq = 1'b1; dataAddr = 32'h4000;
    step();
    for (int c = 1; c <= 8; c++) begin
      chk("t5_busreq_hi", busReq, 1);
      chk("t5_no_ready", dataReady, 0);
      step();
    end
    chk("t5_to_busreq", busReq, 0);
    chk("t5_to_resp", {dataReady, dataErr, dataRdata}, {1'b1, 1'b1, 32'h0});
    dataReq = 1'b0;
    step();
    step();
    busAck = 1'b1; busRdata = 32'hFFFF_FFFF;
    step();
    busAck = 1'b0;
    chk("t5_late_ack", {dataReady, instReady, busReq}, 0);
    chk("t5_hold", {dataErr, dataRdata}, {1'b1, 32'h0});

    // 5b. Ack in the 8th cycle is a normal completion
    dataReq = 1'b1; dataAddr = 32'h4004;
    step();
    for (int c = 1; c < 8; c++) step();
    chk("t5b_c8_busreq", busReq, 1);
    busAck = 1'b1; busRdata = 32'h5555_AAAA;
    step();
    busAck = 1'b0;
    chk("t5b_resp", {dataReady, dataErr, dataRdata}, {1'b1, 1'b0, 32'h5555_AAAA});
    chk("t5b_inst_hold", {instRdata, instErr}, {32'hA000_0004, 1'b0});
    dataReq = 1'b0;
    step();

    // 6. Asynchronous reset during BUSY
    dataReq = 1'b1; dataAddr = 32'h5000;
    step();
    step();
    chk("t6_busy", busReq, 1);
    resetn = 1'b0;
    #1;
    chk("t6_async_busreq", busReq, 0);
    chk("t6_async_outs", {instRdata, dataRdata, busAddr, dataErr, instErr, dataReady, instReady}, 0);
    dataReq = 1'b0;
    step();
    step();
    resetn = 1'b1;
    step();
    busAck = 1'b1; busRdata = 32'h1234_5678;
    step();
    busAck = 1'b0;
    chk("t6_spurious", {busReq, dataReady, instReady}, 0);
    step();
    chk("t6_after", {busReq, dataReady, instReady, dataRdata}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
